imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 131 +++++++++++++
 tb/tb_imem_boot_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes it into
// instruction memory and keeps the core in reset until the checksum is confirmed.
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        SYNC,
        CNT_HI,
        CNT_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                state;
    state_t                nextState;
    logic [7:0]            countHi;
    logic [15:0]           wordCount;
    logic [ADDR_WIDTH:0]   wordIdx;
    logic [1:0]            byteLane;
    logic [7:0]            checksum;
    logic [23:0]           wordBuf;
    logic                  accept;
    logic [15:0]           rxCount;
    logic                  lastWord;

    assign accept   = rx_valid && rx_ready;
    assign rxCount  = {countHi, rx_data};
    assign lastWord = (16'(wordIdx) + 16'd1) == wordCount;

    // Frame parser transitions; outputs are registered from nextState below.
    always_comb begin
        nextState = state;
        case (state)
            SYNC: begin
                if (accept && rx_data == SYNC_BYTE) nextState = CNT_HI;
            end
            CNT_HI: begin
                if (accept) nextState = CNT_LO;
            end
            CNT_LO: begin
                if (accept) begin
                    if ({1'b0, rxCount} > CAPACITY) nextState = ERR;
                    else if (rxCount == 16'd0)      nextState = CHK;
                    else                            nextState = DATA;
                end
            end
            DATA: begin
                if (accept && byteLane == 2'd3 && lastWord) nextState = CHK;
            end
            CHK: begin
                if (accept) nextState = (rx_data == checksum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (reload) nextState = SYNC;
            end
            default: nextState = SYNC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= SYNC;
            rx_ready   <= 1'b1;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            countHi    <= '0;
            wordCount  <= '0;
            wordIdx    <= '0;
            byteLane   <= '0;
            checksum   <= '0;
            wordBuf    <= '0;
        end else begin
            state      <= nextState;
            rx_ready   <= (nextState != DONE) && (nextState != ERR);
            core_reset <= (nextState != DONE);
            load_done  <= (nextState == DONE);
            load_error <= (nextState == ERR);
            imem_we    <= 1'b0;

            if (nextState == SYNC) begin
                wordIdx  <= '0;
                byteLane <= '0;
                checksum <= '0;
            end

            if (accept) begin
                case (state)
                    CNT_HI: countHi   <= rx_data;
                    CNT_LO: wordCount <= rxCount;
                    DATA: begin
                        // Big-endian: earlier bytes shift toward bit 31.
                        checksum <= checksum ^ rx_data;
                        byteLane <= byteLane + 2'd1;
                        wordBuf  <= {wordBuf[15:0], rx_data};
                        if (byteLane == 2'd3) begin
                            imem_wdata <= {wordBuf, rx_data};
                            imem_addr  <= wordIdx[ADDR_WIDTH-1:0];
                            imem_we    <= 1'b1;
                            wordIdx    <= wordIdx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_imem_boot_loader;

    localparam int         AW   = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] byteQ_t[$];

    logic          CLK = 1'b0;
    logic          Reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          load_done;
    logic          load_error;

    int          checkCount = 0;
    int          passCount  = 0;
    int          backToBack = 0;
    logic        weLast     = 1'b0;
    logic [39:0] obsWrites[$];
    logic [39:0] expWrites[$];
    int          expResult;
    byteQ_t      txQ;

    imem_boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 CLK = ~CLK;

    // Collect every memory write; a write strobe must never last two cycles.
    always @(negedge CLK) begin
        if (imem_we) begin
            obsWrites.push_back({imem_addr, imem_wdata});
            if (weLast) backToBack++;
        end
        weLast = imem_we;
    end

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Frame-level reference: result 0 = incomplete, 1 = loaded, 2 = rejected.
    function automatic void modelFrame(input byteQ_t q);
        int          i;
        int          n;
        logic [7:0]  chk;
        logic [31:0] w;
        expWrites.delete();
        i = 0;
        while (i < q.size() && q[i] != SYNC) i++;
        if (i + 2 >= q.size()) begin
            expResult = 0;
            return;
        end
        n = {q[i+1], q[i+2]};
        i += 3;
        if (n > (1 << AW)) begin
            expResult = 2;
            return;
        end
        chk = 8'h00;
        for (int k = 0; k < n; k++) begin
            w = {q[i], q[i+1], q[i+2], q[i+3]};
            chk = chk ^ q[i] ^ q[i+1] ^ q[i+2] ^ q[i+3];
            expWrites.push_back({8'(k), w});
            i += 4;
        end
        expResult = (q[i] == chk) ? 1 : 2;
    endfunction

    function automatic void buildFrame(input int garbage, input int n, input bit corrupt);
        logic [7:0]  b;
        logic [7:0]  chk;
        logic [15:0] n16;
        logic [31:0] w;
        txQ.delete();
        repeat (garbage) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            txQ.push_back(b);
        end
        n16 = 16'(n);
        txQ.push_back(SYNC);
        txQ.push_back(n16[15:8]);
        txQ.push_back(n16[7:0]);
        chk = 8'h00;
        repeat (n) begin
            w = $urandom;
            txQ.push_back(w[31:24]);
            txQ.push_back(w[23:16]);
            txQ.push_back(w[15:8]);
            txQ.push_back(w[7:0]);
            chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
        txQ.push_back(chk);
    endfunction

    // Feeds txQ with idle gaps; stops early once the loader stops accepting.
    task automatic applyStimulus(input int minGap, input int maxGap, input bit randReload);
        foreach (txQ[i]) begin
            int gap;
            gap = $urandom_range(maxGap, minGap);
            repeat (gap) begin
                @(negedge CLK);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                reload   = (randReload && rx_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge CLK);
            if (!rx_ready) begin
                rx_valid = 1'b0;
                reload   = 1'b0;
                return;
            end
            rx_valid = 1'b1;
            rx_data  = txQ[i];
            reload   = randReload ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge CLK);
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic runFrame(input string tag, input int minGap, input int maxGap);
        obsWrites.delete();
        modelFrame(txQ);
        applyStimulus(minGap, maxGap, 1'b1);
        #1;
        checkOutput({tag, ".nWrites"}, 40'(obsWrites.size()), 40'(expWrites.size()));
        foreach (expWrites[i])
            if (i < obsWrites.size()) checkOutput({tag, ".write"}, obsWrites[i], expWrites[i]);
        checkOutput({tag, ".loadDone"},  40'(load_done),  40'(expResult == 1));
        checkOutput({tag, ".loadError"}, 40'(load_error), 40'(expResult == 2));
        checkOutput({tag, ".coreReset"}, 40'(core_reset), 40'(expResult != 1));
        checkOutput({tag, ".rxReady"},   40'(rx_ready),   40'(expResult == 0));
    endtask

    task automatic doReload(input string tag);
        @(negedge CLK);
        reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
        #1;
        checkOutput({tag, ".reloadReady"}, 40'(rx_ready),   40'd1);
        checkOutput({tag, ".reloadErr"},   40'(load_error), 40'd0);
        checkOutput({tag, ".reloadDone"},  40'(load_done),  40'd0);
        checkOutput({tag, ".reloadCore"},  40'(core_reset), 40'd1);
    endtask

    initial begin
        Reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst.rxReady",   40'(rx_ready),   40'd1);
        checkOutput("rst.coreReset", 40'(core_reset), 40'd1);
        checkOutput("rst.we",        40'(imem_we),    40'd0);
        checkOutput("rst.addr",      40'(imem_addr),  40'd0);
        checkOutput("rst.wdata",     40'(imem_wdata), 40'd0);
        checkOutput("rst.done",      40'(load_done),  40'd0);
        checkOutput("rst.error",     40'(load_error), 40'd0);
        Reset = 1'b0;

        txQ = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("single", 0, 0);
        checkOutput("single.word", obsWrites.size() > 0 ? obsWrites[0] : 40'h0, 40'h0020080005);
        doReload("single");

        txQ = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
        runFrame("gaps", 3, 3);
        doReload("gaps");

        txQ = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        runFrame("badChk", 0, 1);
        doReload("badChk");

        txQ = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00};
        runFrame("oversize", 0, 0);
        doReload("oversize");
        txQ = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("afterOversize", 0, 2);
        doReload("afterOversize");

        txQ = '{8'hA5, 8'h00, 8'h00, 8'h00};
        runFrame("zero", 0, 0);
        doReload("zero");

        buildFrame(0, 256, 1'b0);
        runFrame("full", 0, 0);
        doReload("full");

        // Reset after the second data byte must drop the partial word.
        obsWrites.delete();
        txQ = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08};
        applyStimulus(0, 0, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        #1;
        checkOutput("midRst.nWrites",   40'(obsWrites.size()), 40'd0);
        checkOutput("midRst.rxReady",   40'(rx_ready),         40'd1);
        checkOutput("midRst.coreReset", 40'(core_reset),       40'd1);
        Reset = 1'b0;
        txQ = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("afterRst", 0, 0);
        doReload("afterRst");

        for (int f = 0; f < 20; f++) begin
            buildFrame($urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3) == 0);
            runFrame("rand", 0, 2);
            doReload("rand");
        end

        checkOutput("weBackToBack", 40'(backToBack), 40'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
